// File: rtl/conv_frame_sequencer_if.sv
// Host-side bundle of the convolution frame sequencer: start/config,
// load and readout handshakes, bank controls and status strobes.
interface conv_frame_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int COL_W  = 10
);
  logic              i_start;
  logic [ADDR_W-1:0] i_height;
  logic [COL_W-1:0]  i_width;
  logic              i_wvalid;
  logic              o_wready;
  logic              o_wr_en;
  logic              i_ordy;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_addr;
  logic              o_sop;
  logic              o_eop;
  logic              o_chblk;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_start, i_height, i_width, i_wvalid, i_ordy,
    input  o_wready, o_wr_en, o_rd_en, o_addr,
    input  o_sop, o_eop, o_chblk, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_height, i_width, i_wvalid, i_ordy,
    output o_wready, o_wr_en, o_rd_en, o_addr,
    output o_sop, o_eop, o_chblk, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the column-bank convolution MCU:
// LOAD columns, PROC sweep (+drain), OUT readout, rotating N+2 banks.
module conv_frame_sequencer #(
  parameter int N        = 2,
  parameter int ADDR_W   = 10,
  parameter int COL_W    = 10,
  parameter int PROC_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  conv_frame_sequencer_if.slave bus
);

  localparam int DW = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;
  localparam logic [DW-1:0] DRN_LAST =
    DW'((PROC_LAT > 0) ? PROC_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LCHG,
    S_PROC,
    S_DRAIN,
    S_OUT,
    S_OCHG
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] height_q;
  logic [COL_W-1:0]  cols_left;
  logic [COL_W-1:0]  ld_cnt;
  logic [COL_W-1:0]  ld_tgt;
  logic [DW-1:0]     drn;
  logic              err_q;

  logic              cfg_ok;
  logic              accept;
  logic              rd_out;
  logic              last_ld;
  logic [ADDR_W-1:0] h_last;
  logic [ADDR_W-1:0] o_last;
  logic [COL_W-1:0]  left_nxt;

  assign cfg_ok = (bus.i_height >= ADDR_W'(N + 1)) &&
                  (bus.i_width  >= COL_W'(N + 1));
  assign accept   = (state == S_LOAD) && bus.i_wvalid;
  assign rd_out   = (state == S_OUT) && bus.i_ordy;
  assign last_ld  = (ld_cnt == ld_tgt);
  assign h_last   = height_q - ADDR_W'(1);
  assign o_last   = height_q - ADDR_W'(N) - ADDR_W'(1);
  // cols_left counts columns not yet loaded into the banks
  assign left_nxt = cols_left - ld_tgt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.i_start && cfg_ok) state_nxt = S_LOAD;
      S_LOAD:
        if (accept && addr == h_last) state_nxt = S_LCHG;
      S_LCHG:
        state_nxt = last_ld ? S_PROC : S_LOAD;
      S_PROC:
        if (addr == h_last)
          state_nxt = (PROC_LAT == 0) ? S_OUT : S_DRAIN;
      S_DRAIN:
        if (drn == DRN_LAST) state_nxt = S_OUT;
      S_OUT:
        if (rd_out && addr == o_last) state_nxt = S_OCHG;
      S_OCHG:
        state_nxt = (left_nxt != '0) ? S_LOAD : S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      height_q  <= '0;
      cols_left <= '0;
      ld_cnt    <= '0;
      ld_tgt    <= '0;
      drn       <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && bus.i_start && !cfg_ok;
      unique case (state)
        S_IDLE:
          if (bus.i_start && cfg_ok) begin
            height_q  <= bus.i_height;
            cols_left <= bus.i_width;
            ld_tgt    <= COL_W'(N + 1);
            ld_cnt    <= '0;
            addr      <= '0;
          end
        S_LOAD:
          if (accept) begin
            if (addr == h_last) begin
              addr   <= '0;
              ld_cnt <= ld_cnt + COL_W'(1);
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        S_LCHG:
          if (last_ld) ld_cnt <= '0;
        S_PROC: begin
          drn  <= '0;
          addr <= (addr == h_last) ? '0 : addr + ADDR_W'(1);
        end
        S_DRAIN:
          drn <= drn + DW'(1);
        S_OUT:
          if (rd_out)
            addr <= (addr == o_last) ? '0 : addr + ADDR_W'(1);
        S_OCHG: begin
          cols_left <= left_nxt;
          ld_tgt    <= COL_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_sop    = 1'b1;
    bus.o_eop    = 1'b1;
    bus.o_wready = 1'b0;
    bus.o_rd_en  = 1'b0;
    bus.o_chblk  = 1'b0;
    bus.o_done   = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_LOAD: begin
        {bus.o_eop, bus.o_sop} = 2'b00;
        bus.o_wready = 1'b1;
      end
      S_LCHG: begin
        {bus.o_eop, bus.o_sop} = 2'b00;
        bus.o_chblk = 1'b1;
      end
      S_PROC: begin
        {bus.o_eop, bus.o_sop} = 2'b01;
        bus.o_rd_en = 1'b1;
      end
      S_DRAIN:
        {bus.o_eop, bus.o_sop} = 2'b01;
      S_OUT: begin
        {bus.o_eop, bus.o_sop} = 2'b10;
        bus.o_rd_en = bus.i_ordy;
      end
      S_OCHG: begin
        {bus.o_eop, bus.o_sop} = 2'b10;
        bus.o_chblk = 1'b1;
        bus.o_done  = (left_nxt == '0);
      end
      default: ;
    endcase
  end

  assign bus.o_wr_en = bus.o_wready & bus.i_wvalid;
  assign bus.o_addr  = addr;
  assign bus.o_busy  = (state != S_IDLE);
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: per-frame expected event streams
// compared cycle by cycle against two DUTs (PROC_LAT 3 and 0).
`timescale 1ns/1ps
module tb_conv_frame_sequencer;
  localparam int N  = 2;
  localparam int AW = 10;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_frame_sequencer_if #(.ADDR_W(AW), .COL_W(CW)) bus0 ();
  conv_frame_sequencer_if #(.ADDR_W(AW), .COL_W(CW)) bus1 ();

  conv_frame_sequencer #(
    .N(N), .ADDR_W(AW), .COL_W(CW), .PROC_LAT(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  conv_frame_sequencer #(
    .N(N), .ADDR_W(AW), .COL_W(CW), .PROC_LAT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    int kind;
    int ph;
    int done;
    int addr;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int n_chk = 0;
  int n_err = 0;
  int prev_ph[2];
  int prev_ch[2];
  int drain[2];
  int done_cnt[2];
  int nw[2];
  int nro[2];
  int nch[2];
  int mode = 0;
  bit stall_used;
  int stall_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qsz(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic ev_t qpop(input int k);
    ev_t e;
    if (k == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    return e;
  endfunction

  task automatic qpush(input int k, input int kind, input int ph,
                       input int dn, input int a);
    ev_t e;
    e.kind = kind; e.ph = ph; e.done = dn; e.addr = a;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected frame: first pass loads N+1 columns, each later pass one;
  // every pass sweeps h rows then reads out h-N valid rows.
  task automatic build(input int k, input int h, input int w);
    int passes;
    int ncols;
    passes = w - N;
    for (int p = 0; p < passes; p++) begin
      ncols = (p == 0) ? N + 1 : 1;
      for (int c = 0; c < ncols; c++) begin
        for (int a = 0; a < h; a++) qpush(k, 0, 0, 0, a);
        qpush(k, 3, 0, 0, 0);
      end
      for (int a = 0; a < h; a++) qpush(k, 1, 1, 0, a);
      for (int a = 0; a < h - N; a++) qpush(k, 2, 2, 0, a);
      qpush(k, 3, 2, (p == passes - 1) ? 1 : 0, 0);
    end
  endtask

  task automatic trk_reset();
    for (int k = 0; k < 2; k++) begin
      prev_ph[k] = 3; prev_ch[k] = 0; drain[k] = 0;
    end
  endtask

  task automatic sample(input int k, input logic busy, input logic wr,
                        input logic rd, input logic ch, input logic dn,
                        input logic sop, input logic eop,
                        input logic wrdy, input logic wv,
                        input logic [AW-1:0] addr);
    int ph;
    int nev;
    int kind;
    int plat;
    ev_t e;
    ph   = {30'd0, eop, sop};
    nev  = int'(wr) + int'(rd) + int'(ch);
    plat = (k == 0) ? 3 : 0;
    if (!busy) begin
      chk("idle_phase", ph, 3);
      chk("idle_strobes", nev + int'(dn), 0);
    end else begin
      chk("one_event", int'(nev <= 1), 1);
      chk("wr_en", int'(wr), int'(wrdy & wv));
      chk("wready", int'(wrdy), int'(ph == 0 && !ch));
      if (ph == 1 && !rd) drain[k]++;
      if (ph == 2 && prev_ph[k] == 1) begin
        chk("drain_len", drain[k], plat);
        drain[k] = 0;
      end
      if (ch) begin
        chk("chblk_repeat", prev_ch[k], 0);
        chk("chblk_phase", ph, prev_ph[k]);
      end
      if (ph == 2 && !rd && !ch && qsz(k) > 0) begin
        e = qfront(k);
        chk("stall_addr", int'(addr), e.addr);
      end
      if (nev == 1) begin
        kind = wr ? 0 : (rd ? ((ph == 1) ? 1 : 2) : 3);
        if (kind == 0) nw[k]++;
        if (kind == 2) nro[k]++;
        if (kind == 3) nch[k]++;
        if (qsz(k) == 0) begin
          chk("extra_event", kind, -1);
        end else begin
          e = qpop(k);
          chk("event", kind * 100000 + ph * 10000 +
              int'(dn) * 1000 + int'(addr),
              e.kind * 100000 + e.ph * 10000 +
              e.done * 1000 + e.addr);
        end
      end else begin
        chk("done_alone", int'(dn), 0);
      end
    end
    if (dn) done_cnt[k]++;
    prev_ph[k] = ph;
    prev_ch[k] = int'(ch);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sample(0, bus0.o_busy, bus0.o_wr_en, bus0.o_rd_en, bus0.o_chblk,
             bus0.o_done, bus0.o_sop, bus0.o_eop, bus0.o_wready,
             bus0.i_wvalid, bus0.o_addr);
      sample(1, bus1.o_busy, bus1.o_wr_en, bus1.o_rd_en, bus1.o_chblk,
             bus1.o_done, bus1.o_sop, bus1.o_eop, bus1.o_wready,
             bus1.i_wvalid, bus1.o_addr);
    end
  end

  initial begin
    bus0.i_wvalid = 1'b0;
    bus0.i_ordy   = 1'b0;
    bus1.i_wvalid = 1'b1;
    bus1.i_ordy   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          bus0.i_wvalid = ~bus0.i_wvalid;
          bus0.i_ordy   = 1'b1;
          if (!stall_used && bus0.o_eop && !bus0.o_sop &&
              !bus0.o_chblk && bus0.o_addr == AW'(1)) begin
            if (stall_cnt < 5) begin
              bus0.i_ordy = 1'b0;
              stall_cnt++;
            end else begin
              stall_used = 1'b1;
            end
          end
        end
        2: begin
          bus0.i_wvalid = 1'($urandom_range(0, 1));
          bus0.i_ordy   = ($urandom_range(0, 3) != 0);
        end
        default: begin
          bus0.i_wvalid = 1'b1;
          bus0.i_ordy   = 1'b1;
        end
      endcase
    end
  end

  task automatic set_start(input int k, input logic s,
                           input int h, input int w);
    if (k == 0) begin
      bus0.i_start = s; bus0.i_height = AW'(h); bus0.i_width = CW'(w);
    end else begin
      bus1.i_start = s; bus1.i_height = AW'(h); bus1.i_width = CW'(w);
    end
  endtask

  task automatic run_frame(input int k, input int h, input int w,
                           input bit poke, input string tag);
    int d0;
    bit got;
    bit seen;
    nw[k] = 0; nro[k] = 0; nch[k] = 0;
    stall_used = 1'b0; stall_cnt = 0;
    build(k, h, w);
    d0 = done_cnt[k];
    @(posedge clk); #1;
    set_start(k, 1'b1, h, w);
    @(posedge clk); #1;
    set_start(k, 1'b0, h, w);
    if (poke) begin
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
        @(posedge clk); #1;
        if (!bus0.o_eop && bus0.o_sop) seen = 1'b1;
      end
      chk({"reach_proc_", tag}, int'(seen), 1);
      set_start(k, 1'b1, 3, 3);
      @(posedge clk); #1;
      set_start(k, 1'b0, 3, 3);
    end
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge clk); #1;
      if (done_cnt[k] != d0) got = 1'b1;
    end
    chk({"frame_done_", tag}, int'(got), 1);
    repeat (4) @(posedge clk);
    #1;
    chk({"done_once_", tag}, done_cnt[k] - d0, 1);
    chk({"model_left_", tag}, qsz(k), 0);
    chk({"busy_end_", tag},
        int'((k == 0) ? bus0.o_busy : bus1.o_busy), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({"rst_addr_", tag}, int'(bus0.o_addr), 0);
    chk({"rst_phase_", tag}, int'({bus0.o_eop, bus0.o_sop}), 3);
    chk({"rst_chblk_", tag}, int'(bus0.o_chblk), 0);
    chk({"rst_wready_", tag}, int'(bus0.o_wready), 0);
    chk({"rst_wr_en_", tag}, int'(bus0.o_wr_en), 0);
    chk({"rst_rd_en_", tag}, int'(bus0.o_rd_en), 0);
    chk({"rst_busy_", tag}, int'(bus0.o_busy), 0);
    chk({"rst_done_", tag}, int'(bus0.o_done), 0);
    chk({"rst_err_", tag}, int'(bus0.o_err), 0);
  endtask

  initial begin
    bit hit;
    int h;
    int w;
    set_start(0, 1'b0, 4, 4);
    set_start(1, 1'b0, 3, 3);
    trk_reset();
    done_cnt[0] = 0; done_cnt[1] = 0;
    #23;
    chk_reset_outs("init");
    rst = 1'b1;

    build(0, 4, 4);
    chk("model_len_4x4", q0.size(), 34);
    q0.delete();

    mode = 0;
    run_frame(0, 4, 4, 1'b0, "base");
    chk("words_in_base", nw[0], 16);
    chk("words_out_base", nro[0], 4);
    chk("chblk_base", nch[0], 6);

    mode = 1;
    run_frame(0, 4, 4, 1'b0, "stall");
    chk("words_in_stall", nw[0], 16);
    chk("words_out_stall", nro[0], 4);
    chk("stall_applied", stall_cnt, 5);

    mode = 0;
    @(posedge clk); #1;
    set_start(0, 1'b1, 2, 4);
    @(posedge clk); #1;
    set_start(0, 1'b0, 2, 4);
    chk("err_pulse", int'(bus0.o_err), 1);
    chk("err_busy", int'(bus0.o_busy), 0);
    chk("err_phase", int'({bus0.o_eop, bus0.o_sop}), 3);
    @(posedge clk); #1;
    chk("err_clear", int'(bus0.o_err), 0);
    chk("err_idle", int'(bus0.o_busy), 0);

    nw[0] = 0;
    build(0, 4, 4);
    @(posedge clk); #1;
    set_start(0, 1'b1, 4, 4);
    @(posedge clk); #1;
    set_start(0, 1'b0, 4, 4);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #2;
      if (nw[0] >= 6) hit = 1'b1;
    end
    chk("reach_6_accepts", int'(hit), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("mid");
    q0.delete();
    trk_reset();
    #20;
    rst = 1'b1;
    run_frame(0, 4, 4, 1'b0, "after_rst");
    chk("words_in_after_rst", nw[0], 16);
    chk("chblk_after_rst", nch[0], 6);

    mode = 2;
    run_frame(0, 5, 4, 1'b1, "poke");
    chk("words_in_poke", nw[0], 20);
    chk("words_out_poke", nro[0], 6);

    for (int r = 0; r < 3; r++) begin
      h = $urandom_range(3, 7);
      w = $urandom_range(3, 6);
      run_frame(0, h, w, 1'b0, "rand");
      chk("words_in_rand", nw[0], h * w);
      chk("words_out_rand", nro[0], (h - N) * (w - N));
      chk("chblk_rand", nch[0], w + (w - N));
    end

    build(1, 3, 3);
    chk("model_len_3x3", q1.size(), 17);
    q1.delete();
    run_frame(1, 3, 3, 1'b0, "lat0");
    chk("words_in_lat0", nw[1], 9);
    chk("words_out_lat0", nro[1], 1);
    chk("chblk_lat0", nch[1], 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
